// File: rtl/n101_tl2icb_bridge_pkg.sv
// Shared TileLink-UL definitions for the TL-to-ICB bridge: opcodes, size limit
// and field widths of the outstanding-request entry.
package n101_tl_defs;

    localparam logic [2:0] TL_PUTFULL    = 3'd0;
    localparam logic [2:0] TL_PUTPARTIAL = 3'd1;
    localparam logic [2:0] TL_GET        = 3'd4;

    localparam logic [2:0] TL_ACK        = 3'd0;
    localparam logic [2:0] TL_ACKDATA    = 3'd1;

    // Widest access the 32-bit ICB side can carry in one beat (log2 bytes).
    localparam logic [2:0] TL_MAX_SIZE   = 3'd2;

    localparam int OE_READ_W    = 1;
    localparam int OE_SIZE_W    = 3;
    localparam int OE_ADDR_LO_W = 2;
    localparam int OE_LERR_W    = 1;

    function automatic logic tl_req_legal(input logic [2:0] opcode, input logic [2:0] size);
        return ((opcode == TL_GET) || (opcode == TL_PUTFULL) || (opcode == TL_PUTPARTIAL))
               && (size <= TL_MAX_SIZE);
    endfunction

endpackage

// File: rtl/n101_tl2icb_outs_fifo.sv
// Generic in-order flop FIFO; pop data is the registered head, no bypass.
// Latency 1 cycle push-to-head; push ignored when full, pop ignored when empty.
module n101_tl2icb_outs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/n101_tl2icb_bridge.sv
// TL-UL responder to ICB initiator bridge with in-order outstanding tracking and a registered D stage.
// Latency: ICB rsp accepted in cycle N -> D beat in N+1; A stalls when OUTS_DEPTH requests are in flight or on ICB cmd backpressure.
module n101_tl2icb_bridge
    import n101_tl_defs::*;
#(
    parameter int AW         = 32,
    parameter int TL_AW      = 29,
    parameter int SRC_W      = 5,
    parameter int OUTS_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_param,
    input  logic [2:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [TL_AW-1:0] a_address,
    input  logic [3:0]       a_mask,
    input  logic [31:0]      a_data,

    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [1:0]       d_param,
    output logic [2:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic             d_sink,
    output logic [1:0]       d_addr_lo,
    output logic [31:0]      d_data,
    output logic             d_error,

    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic [AW-1:0]    icb_cmd_addr,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,

    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);

    typedef struct packed {
        logic [OE_READ_W-1:0]    read;
        logic [OE_SIZE_W-1:0]    size;
        logic [SRC_W-1:0]        source;
        logic [OE_ADDR_LO_W-1:0] addr_lo;
        logic [OE_LERR_W-1:0]    local_err;
    } outs_ent_t;

    localparam int CNT_W = $clog2(OUTS_DEPTH + 1);

    logic             req_legal;
    logic             req_is_get;
    logic             a_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] outs_cnt;
    outs_ent_t        push_ent;
    outs_ent_t        head_ent;
    logic             d_stage_free;
    logic             launch;

    logic             d_valid_q,   d_valid_d;
    logic [2:0]       d_opcode_q,  d_opcode_d;
    logic [2:0]       d_size_q,    d_size_d;
    logic [SRC_W-1:0] d_source_q,  d_source_d;
    logic [1:0]       d_addr_lo_q, d_addr_lo_d;
    logic [31:0]      d_data_q,    d_data_d;
    logic             d_error_q,   d_error_d;

    logic             unused_ok;

    // ---------------- A channel -> ICB command ----------------
    assign req_legal     = tl_req_legal(a_opcode, a_size);
    assign req_is_get    = (a_opcode == TL_GET);

    // Illegal requests never reach ICB, so they must not wait on its ready.
    assign icb_cmd_valid = a_valid & ~fifo_full & req_legal;
    assign a_ready       = ~fifo_full & (req_legal ? icb_cmd_ready : 1'b1);
    assign a_fire        = a_valid & a_ready;

    assign icb_cmd_addr  = AW'(a_address);
    assign icb_cmd_read  = req_is_get;
    assign icb_cmd_wdata = a_data;
    assign icb_cmd_wmask = req_is_get ? 4'b0000 : a_mask;

    // An illegal Get still answers with a dataless ack, so read is qualified by legality.
    assign push_ent.read      = req_is_get & req_legal;
    assign push_ent.size      = a_size;
    assign push_ent.source    = a_source;
    assign push_ent.addr_lo   = a_address[1:0];
    assign push_ent.local_err = ~req_legal;

    n101_tl2icb_outs_fifo #(
        .W     ($bits(outs_ent_t)),
        .DEPTH (OUTS_DEPTH)
    ) u_outs_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (a_fire),
        .push_dat_i (push_ent),
        .pop_i      (launch),
        .head_dat_o (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (outs_cnt)
    );

    // ---------------- ICB response -> registered D stage ----------------
    assign d_stage_free  = ~d_valid_q | d_ready;
    assign launch        = ~fifo_empty & d_stage_free & (head_ent.local_err | icb_rsp_valid);
    assign icb_rsp_ready = ~fifo_empty & ~head_ent.local_err & d_stage_free;

    always_comb begin
        d_valid_d   = d_valid_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_addr_lo_d = d_addr_lo_q;
        d_data_d    = d_data_q;
        d_error_d   = d_error_q;
        if (launch) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = head_ent.read ? TL_ACKDATA : TL_ACK;
            d_size_d    = head_ent.size;
            d_source_d  = head_ent.source;
            d_addr_lo_d = head_ent.addr_lo;
            d_data_d    = (head_ent.read & ~head_ent.local_err) ? icb_rsp_rdata : 32'h0;
            d_error_d   = head_ent.local_err | icb_rsp_err;
        end else if (d_ready) begin
            d_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_addr_lo_q <= '0;
            d_data_q    <= '0;
            d_error_q   <= 1'b0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_addr_lo_q <= d_addr_lo_d;
            d_data_q    <= d_data_d;
            d_error_q   <= d_error_d;
        end
    end

    assign d_valid   = d_valid_q;
    assign d_opcode  = d_opcode_q;
    assign d_param   = 2'b00;
    assign d_size    = d_size_q;
    assign d_source  = d_source_q;
    assign d_sink    = 1'b0;
    assign d_addr_lo = d_addr_lo_q;
    assign d_data    = d_data_q;
    assign d_error   = d_error_q;

    assign unused_ok = ^{a_param, outs_cnt};

    // A response with nothing outstanding means the ICB target broke the protocol.
    rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        icb_rsp_valid |-> !fifo_empty);

endmodule

// File: tb/tb_n101_tl2icb_bridge.sv
module tb_n101_tl2icb_bridge;

    localparam int AW    = 32;
    localparam int TL_AW = 29;
    localparam int SRC_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid, a_ready;
    logic [2:0]       a_opcode, a_param, a_size;
    logic [SRC_W-1:0] a_source;
    logic [TL_AW-1:0] a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic             d_valid, d_ready;
    logic [2:0]       d_opcode, d_size;
    logic [1:0]       d_param, d_addr_lo;
    logic [SRC_W-1:0] d_source;
    logic             d_sink, d_error;
    logic [31:0]      d_data;
    logic             icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [AW-1:0]    icb_cmd_addr;
    logic [31:0]      icb_cmd_wdata;
    logic [3:0]       icb_cmd_wmask;
    logic             icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0]      icb_rsp_rdata;

    always #5 clk = ~clk;

    n101_tl2icb_bridge #(.AW(AW), .TL_AW(TL_AW), .SRC_W(SRC_W), .OUTS_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_addr_lo(d_addr_lo),
        .d_data(d_data), .d_error(d_error),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    typedef struct {
        logic [2:0]       op;
        logic [2:0]       size;
        logic [SRC_W-1:0] src;
        logic [TL_AW-1:0] addr;
        logic [3:0]       mask;
        logic [31:0]      data;
    } req_t;

    typedef struct {
        logic [2:0]       op;
        logic [2:0]       size;
        logic [SRC_W-1:0] src;
        logic [1:0]       lo;
        logic [31:0]      data;
        logic             err;
    } beat_t;

    req_t        req_q[$];
    req_t        tgt_q[$];
    beat_t       exp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] tgt_mem [16];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   afire_cnt = 0;
    int   dfire_cnt = 0;
    bit   a_busy = 0;
    bit   exp_dv = 0;
    bit   rsp_hold = 0, rsp_rand = 0, cmd_rand = 0, gap_rand = 0;
    int   dr_mode = 0;
    req_t cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] op, input logic [2:0] size);
        return (op == 3'd0 || op == 3'd1 || op == 3'd4) && size <= 3'd2;
    endfunction

    function automatic req_t mkreq(input logic [2:0] op, input logic [2:0] size,
                                   input logic [SRC_W-1:0] src, input logic [TL_AW-1:0] addr,
                                   input logic [3:0] mask, input logic [31:0] data);
        req_t r;
        r.op = op; r.size = size; r.src = src; r.addr = addr; r.mask = mask; r.data = data;
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] v;
        v = old;
        for (int i = 0; i < 4; i++) if (m[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    // Reference: what the TL master must see for a request, in acceptance order.
    // Address bit 8 marks a region where the ICB target answers with an error.
    task automatic predict(input req_t r);
        beat_t b;
        bit    rd, e;
        rd = (r.op == 3'd4);
        e  = r.addr[8];
        b.size = r.size; b.src = r.src; b.lo = r.addr[1:0];
        if (!is_legal(r.op, r.size)) begin
            b.op = 3'd0; b.data = 32'h0; b.err = 1'b1;
        end else begin
            b.op   = rd ? 3'd1 : 3'd0;
            b.err  = e;
            b.data = (rd && !e) ? ref_mem[r.addr[5:2]] : 32'h0;
            if (!rd && !e) ref_mem[r.addr[5:2]] = merge(ref_mem[r.addr[5:2]], r.data, r.mask);
        end
        exp_q.push_back(b);
    endtask

    task automatic cycle();
        bit legal;
        @(posedge clk);
        #1;
        cyc++;
        if (!a_busy && req_q.size() > 0 && !(gap_rand && $urandom_range(3) == 0)) begin
            cur = req_q.pop_front();
            a_busy = 1;
        end
        a_valid   = a_busy;
        a_opcode  = cur.op;
        a_size    = cur.size;
        a_source  = cur.src;
        a_address = cur.addr;
        a_mask    = cur.mask;
        a_data    = cur.data;
        a_param   = 3'($urandom_range(7));
        icb_cmd_ready = cmd_rand ? 1'($urandom_range(1)) : 1'b1;
        if (!rsp_hold && tgt_q.size() > 0 && (!rsp_rand || $urandom_range(2) != 0)) begin
            icb_rsp_valid = 1'b1;
            icb_rsp_err   = tgt_q[0].addr[8];
            if (tgt_q[0].op != 3'd4) icb_rsp_rdata = $urandom;
            else if (tgt_q[0].addr[8]) icb_rsp_rdata = 32'h0;
            else icb_rsp_rdata = tgt_mem[tgt_q[0].addr[5:2]];
        end else begin
            icb_rsp_valid = 1'b0;
            icb_rsp_err   = 1'b0;
            icb_rsp_rdata = $urandom;
        end
        d_ready = (dr_mode == 0) ? 1'b1 : (dr_mode == 1) ? 1'($urandom_range(1)) : 1'b0;

        @(negedge clk);
        if (exp_dv) chk("rsp_to_d_latency", 32'(d_valid), 32'd1);
        exp_dv = icb_rsp_valid && icb_rsp_ready;
        if (icb_rsp_valid && icb_rsp_ready) begin
            if (tgt_q[0].op != 3'd4 && !tgt_q[0].addr[8])
                tgt_mem[tgt_q[0].addr[5:2]] = merge(tgt_mem[tgt_q[0].addr[5:2]], tgt_q[0].data, tgt_q[0].mask);
            void'(tgt_q.pop_front());
        end
        if (d_valid) begin
            chk("d_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("d_opcode",  32'(d_opcode),  32'(exp_q[0].op));
                chk("d_size",    32'(d_size),    32'(exp_q[0].size));
                chk("d_source",  32'(d_source),  32'(exp_q[0].src));
                chk("d_addr_lo", 32'(d_addr_lo), 32'(exp_q[0].lo));
                chk("d_data",    d_data,         exp_q[0].data);
                chk("d_error",   32'(d_error),   32'(exp_q[0].err));
                chk("d_param_sink", 32'({d_param, d_sink}), 32'd0);
                if (d_ready) begin
                    void'(exp_q.pop_front());
                    dfire_cnt++;
                end
            end
            if (!d_ready) chk("rsp_rdy_in_stall", 32'(icb_rsp_ready), 32'd0);
        end
        if (a_valid && a_ready) begin
            afire_cnt++;
            legal = is_legal(cur.op, cur.size);
            chk("icb_cmd_valid", 32'(icb_cmd_valid), 32'(legal));
            if (legal) begin
                chk("icb_cmd_addr",  icb_cmd_addr,         32'(cur.addr));
                chk("icb_cmd_read",  32'(icb_cmd_read),    32'(cur.op == 3'd4));
                chk("icb_cmd_wdata", icb_cmd_wdata,        cur.data);
                chk("icb_cmd_wmask", 32'(icb_cmd_wmask),   32'((cur.op == 3'd4) ? 4'h0 : cur.mask));
                tgt_q.push_back(cur);
            end
            predict(cur);
            a_busy = 0;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((req_q.size() > 0 || a_busy || exp_q.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_left", 32'(req_q.size() + exp_q.size() + int'(a_busy)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fc, n;
        req_t r;
        a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0; d_ready = 1; icb_cmd_ready = 1;
        icb_rsp_valid = 0; icb_rsp_rdata = 0; icb_rsp_err = 0;
        cur = mkreq(3'd0, 3'd0, '0, '0, 4'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            tgt_mem[i] = ref_mem[i];
        end
        ref_mem[1] = 32'hDEAD_BEEF;
        tgt_mem[1] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_valid",   32'(d_valid),       32'd0);
        chk("rst_cmd_valid", 32'(icb_cmd_valid), 32'd0);
        chk("rst_rsp_ready", 32'(icb_rsp_ready), 32'd0);
        chk("rst_a_ready",   32'(a_ready),       32'd1);
        chk("rst_d_regs",    d_data | 32'({d_opcode, d_size, d_source, d_addr_lo, d_error}), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Single Get, then a partial write read back through the same word
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd3, 29'h0001_0004, 4'hF, 32'h0));
        drain(50);
        req_q.push_back(mkreq(3'd1, 3'd2, 5'd4, 29'h10, 4'b0011, 32'h1234_5678));
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd5, 29'h10, 4'hF, 32'h0));
        drain(50);

        // Outstanding limit: third Get must stall while responses are withheld
        rsp_hold = 1;
        base = afire_cnt;
        for (int s = 1; s <= 3; s++) req_q.push_back(mkreq(3'd4, 3'd2, 5'(s), 29'(32'h20 + 4*s), 4'hF, 32'h0));
        repeat (6) cycle();
        chk("outs_a_ready",   32'(a_ready),           32'd0);
        chk("outs_cmd_valid", 32'(icb_cmd_valid),     32'd0);
        chk("outs_accepted",  32'(afire_cnt - base),  32'd2);
        rsp_hold = 0;
        drain(50);

        // Local error alone reaches D two cycles after its A fire
        base = afire_cnt;
        req_q.push_back(mkreq(3'd2, 3'd2, 5'd7, 29'h33, 4'hF, 32'h0));
        n = 0;
        while (afire_cnt == base && n < 10) begin cycle(); n++; end
        fc = cyc;
        n = 0;
        while (!d_valid && n < 10) begin cycle(); n++; end
        chk("lerr_latency", 32'(cyc - fc), 32'd2);
        drain(50);

        // Illegal requests interleaved with legal Gets keep order
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd8,  29'h04, 4'hF, 32'h0));
        req_q.push_back(mkreq(3'd2, 3'd2, 5'd9,  29'h08, 4'hF, 32'h0));
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd10, 29'h0C, 4'hF, 32'h0));
        req_q.push_back(mkreq(3'd4, 3'd3, 5'd11, 29'h0D, 4'hF, 32'h0));
        req_q.push_back(mkreq(3'd4, 3'd1, 5'd12, 29'h12, 4'hF, 32'h0));
        drain(80);

        // D backpressure, then streaming at one beat per cycle
        dr_mode = 2;
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd13, 29'h14, 4'hF, 32'h0));
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd14, 29'h18, 4'hF, 32'h0));
        repeat (8) cycle();
        chk("bp_d_valid",   32'(d_valid),       32'd1);
        chk("bp_rsp_ready", 32'(icb_rsp_ready), 32'd0);
        dr_mode = 0;
        base = dfire_cnt;
        repeat (2) cycle();
        chk("stream_beats", 32'(dfire_cnt - base), 32'd2);
        drain(50);

        // Reset with two entries outstanding and a beat held in D
        dr_mode = 2;
        for (int s = 20; s < 23; s++) req_q.push_back(mkreq(3'd4, 3'd2, 5'(s), 29'(4*(s-16)), 4'hF, 32'h0));
        repeat (8) cycle();
        chk("pre_rst_d_valid", 32'(d_valid), 32'd1);
        chk("pre_rst_full",    32'(a_ready || icb_cmd_valid), 32'd0);
        #2;
        a_valid = 0; icb_rsp_valid = 0;
        rst_n = 0;
        #1;
        chk("async_rst_d_valid", 32'(d_valid), 32'd0);
        chk("async_rst_a_ready", 32'(a_ready), 32'd1);
        req_q.delete(); exp_q.delete(); tgt_q.delete();
        a_busy = 0; exp_dv = 0; dr_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        req_q.push_back(mkreq(3'd4, 3'd2, 5'd24, 29'h0001_0004, 4'hF, 32'h0));
        drain(50);

        // Randomized traffic with random readiness on every interface
        cmd_rand = 1; rsp_rand = 1; gap_rand = 1; dr_mode = 1;
        for (int k = 0; k < 300; k++) begin
            r.src  = 5'($urandom_range(31));
            r.addr = 29'($urandom);
            if ($urandom_range(7) != 0) r.addr[8] = 1'b0;
            r.mask = 4'($urandom_range(15));
            r.data = $urandom;
            if ($urandom_range(6) != 0) begin
                case ($urandom_range(2))
                    0: r.op = 3'd0;
                    1: r.op = 3'd1;
                    default: r.op = 3'd4;
                endcase
                r.size = 3'($urandom_range(2));
            end else if ($urandom_range(1) == 0) begin
                r.op   = 3'd2 + 3'($urandom_range(5));
                if (r.op == 3'd4) r.op = 3'd3;
                r.size = 3'($urandom_range(2));
            end else begin
                r.op   = 3'd4;
                r.size = 3'd3 + 3'($urandom_range(4));
            end
            req_q.push_back(r);
        end
        drain(20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/n101_tl2icb_bridge.md
Name: n101_tl2icb_bridge

Overview:
TileLink-UL responder to ICB initiator bridge: accepts TL-UL A-channel requests from a TileLink master and issues them as ICB commands to an ICB peripheral. ICB responses return as TL-UL D-channel beats.
Tracks up to OUTS_DEPTH in-order outstanding requests and registers the D channel.
Used where TileLink-generated logic must drive native N101 ICB peripherals. It is the counterpart of the existing ICB-to-TileLink wrapping around the QSPI controller.

Parameters:
AW, `N101_ADDR_SIZE (32), ICB address width
TL_AW, 29, TL-UL address width
SRC_W, 5, TL source width
OUTS_DEPTH, 2, max outstanding requests (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  TL A valid
a_ready  out  1  TL A ready
a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
a_param  in  3  ignored
a_size  in  3  log2 bytes
a_source  in  SRC_W  request ID
a_address  in  TL_AW  byte address
a_mask  in  4  byte lanes
a_data  in  32  write data
d_valid  out  1  TL D valid
d_ready  in  1  TL D ready
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_param  out  2  always 0
d_size  out  3  echoed a_size
d_source  out  SRC_W  echoed a_source
d_sink  out  1  always 0
d_addr_lo  out  2  echoed a_address[1:0]
d_data  out  32  read data, 0 for writes
d_error  out  1  error
icb_cmd_valid  out  1  ICB cmd valid
icb_cmd_ready  in  1  ICB cmd ready
icb_cmd_addr  out  AW  zero-extended a_address
icb_cmd_read  out  1  a_opcode==4
icb_cmd_wdata  out  32  a_data
icb_cmd_wmask  out  4  a_mask for Put, 4'b0 for Get
icb_rsp_valid  in  1  ICB rsp valid
icb_rsp_ready  out  1  ICB rsp ready
icb_rsp_rdata  in  32  read data
icb_rsp_err  in  1  response error

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low.
- Reset values: FIFO empty (count 0, pointers 0), d_valid=0, all D data registers 0. Combinational outputs follow from these values.
- Legal request: opcode in {0,1,4} and a_size<=2. Any other request is illegal.
- A channel, combinational:
  - icb_cmd_valid = a_valid & ~full & legal.
  - a_ready = ~full & (legal ? icb_cmd_ready : 1).
- Illegal requests are accepted without an ICB command and flagged local_err.
- On A fire, push {read, size, source, addr_lo, local_err} into the outstanding FIFO. Depth is OUTS_DEPTH; the count is clog2(OUTS_DEPTH+1) bits wide.
- Response launch condition L: FIFO non-empty & (~d_valid | d_ready) & (head.local_err | icb_rsp_valid).
- icb_rsp_ready = FIFO non-empty & ~head.local_err & (~d_valid | d_ready).
- A local_err head entry never consumes an ICB response.
- On L, load the D registers and pop the FIFO in the same cycle:
  - d_opcode = head.read ? 1 : 0.
  - d_data = (head.read & ~head.local_err) ? icb_rsp_rdata : 0.
  - d_error = head.local_err | icb_rsp_err.
  - size, source and addr_lo come from the head entry.
- d_valid: set on L; cleared on d_ready when L is not also true. Back-to-back beats sustain 1 beat/cycle.
- Latency: ICB rsp accepted in cycle N gives d_valid in cycle N+1. A local error with an empty D stage reaches D 2 cycles after A fire.
- Responses stay in request order.
- Simultaneous push and pop: both occur, count unchanged. A full FIFO with a pop in the same cycle still deasserts a_ready; there is no bypass.
- ICB response with an empty FIFO: icb_rsp_ready=0, response ignored. This is a protocol violation; flag it with an assertion.
- Reset mid-operation drops all outstanding entries and any pending D beat. The ICB target must be reset in the same domain.

Decomposition:
- Shared package n101_tl_defs: TL opcode constants (GET=4, PUTFULL=0, PUTPARTIAL=1, ACK=0, ACKDATA=1) and the outstanding-entry field widths.
- One sub-module: n101_tl2icb_outs_fifo, a generic synchronous in-order FIFO (parameterised width/depth, flops, async active-low reset).

Test Plan:
- Get: addr 0x0001_0004, source 3, size 2 → icb_cmd_addr 0x0001_0004, read=1; rsp rdata 0xDEADBEEF → next cycle d_opcode 1, d_data 0xDEADBEEF, d_source 3, d_addr_lo 0, d_error 0.
- PutPartial: addr 0x10, mask 4'b0011, data 0x1234_5678 → icb_cmd_wmask 0011, read=0; rsp → d_opcode 0, d_data 0.
- Outstanding limit, OUTS_DEPTH=2: three Gets with the ICB response held off → third stalls with a_ready=0. Responses released in order (sources 1, 2, 3).
- Illegal opcode 2 or size 3 → no icb_cmd_valid; d_error=1 and d_opcode 0, with no ICB response consumed. Check this interleaved between two legal Gets for correct ordering.
- D backpressure: d_ready=0 for 5 cycles with an ICB response pending → icb_rsp_ready=0 and d_* stable. Once d_ready=1, the beats stream at 1 per cycle.
- Assert rst_n low with 2 outstanding requests and d_valid=1 → d_valid 0 immediately (asynchronously). After release, a new Get completes normally.
